// File: rtl/core_pkg.sv
// Shared widths and the ID/EX control bundle for the 5-stage RV32 core.
package core_pkg;

    localparam int XLEN        = 32;
    localparam int REG_IDX_W   = 5;
    localparam int RESULTSRC_W = 2;
    localparam int ALUCTRL_W   = 3;

    typedef struct packed {
        logic                   regWrite;
        logic [RESULTSRC_W-1:0] resultSrc;
        logic                   memWrite;
        logic                   jump;
        logic                   branch;
        logic [ALUCTRL_W-1:0]   aluControl;
        logic                   aluSrc;
    } idExCtrl_t;

    localparam int CTRL_W = $bits(idExCtrl_t);

endpackage

// File: rtl/flopenrc.sv
// Parameterized flop with synchronous reset, synchronous clear and load enable.
// Latency: 1 cycle from d to q.
// Backpressure: en low holds q; reset and clear override en.
module flopenrc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_id_ex_pipe.sv
// ID->EX pipeline register; FlushE inserts a bubble. StallE exists only with ID_EX_STALL_EN.
// Latency: 1 cycle, no combinational input-to-output path.
// Backpressure: StallE (when compiled in) freezes all fields; FlushE overrides it.
module register_id_ex_pipe
    import core_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   FlushE,
`ifdef ID_EX_STALL_EN
    input  logic                   StallE,
`endif
    input  logic [XLEN-1:0]        PCD,
    input  logic [XLEN-1:0]        PCPlus4D,
    input  logic [XLEN-1:0]        RD1D,
    input  logic [XLEN-1:0]        RD2D,
    input  logic [XLEN-1:0]        ImmExtD,
    input  logic [REG_IDX_W-1:0]   Rs1D,
    input  logic [REG_IDX_W-1:0]   Rs2D,
    input  logic [REG_IDX_W-1:0]   RdD,
    input  logic                   RegWriteD,
    input  logic                   MemWriteD,
    input  logic                   JumpD,
    input  logic                   BranchD,
    input  logic                   ALUSrcD,
    input  logic [RESULTSRC_W-1:0] ResultSrcD,
    input  logic [ALUCTRL_W-1:0]   ALUControlD,
    output logic [XLEN-1:0]        PCE,
    output logic [XLEN-1:0]        PCPlus4E,
    output logic [XLEN-1:0]        RD1E,
    output logic [XLEN-1:0]        RD2E,
    output logic [XLEN-1:0]        ImmExtE,
    output logic [REG_IDX_W-1:0]   Rs1E,
    output logic [REG_IDX_W-1:0]   Rs2E,
    output logic [REG_IDX_W-1:0]   RdE,
    output logic                   RegWriteE,
    output logic                   MemWriteE,
    output logic                   JumpE,
    output logic                   BranchE,
    output logic                   ALUSrcE,
    output logic [RESULTSRC_W-1:0] ResultSrcE,
    output logic [ALUCTRL_W-1:0]   ALUControlE
);

    localparam int DATA_W = 5 * XLEN;
    localparam int IDX_W  = 3 * REG_IDX_W;

    logic              loadEn;
    logic [DATA_W-1:0] dataD, dataE;
    logic [IDX_W-1:0]  idxD, idxE;
    idExCtrl_t         ctrlD, ctrlE;

`ifdef ID_EX_STALL_EN
    assign loadEn = ~StallE;
`else
    assign loadEn = 1'b1;
`endif

    assign dataD = {PCD, PCPlus4D, RD1D, RD2D, ImmExtD};
    assign idxD  = {Rs1D, Rs2D, RdD};

    always_comb begin
        ctrlD            = '0;
        ctrlD.regWrite   = RegWriteD;
        ctrlD.resultSrc  = ResultSrcD;
        ctrlD.memWrite   = MemWriteD;
        ctrlD.jump       = JumpD;
        ctrlD.branch     = BranchD;
        ctrlD.aluControl = ALUControlD;
        ctrlD.aluSrc     = ALUSrcD;
    end

    flopenrc #(.WIDTH(DATA_W)) dataReg (
        .clk   (clk),
        .reset (reset),
        .clear (FlushE),
        .en    (loadEn),
        .d     (dataD),
        .q     (dataE)
    );

    flopenrc #(.WIDTH(IDX_W)) idxReg (
        .clk   (clk),
        .reset (reset),
        .clear (FlushE),
        .en    (loadEn),
        .d     (idxD),
        .q     (idxE)
    );

    // Clearing the control group is what turns a flushed slot into a NOP.
    flopenrc #(.WIDTH(CTRL_W)) ctrlReg (
        .clk   (clk),
        .reset (reset),
        .clear (FlushE),
        .en    (loadEn),
        .d     (ctrlD),
        .q     (ctrlE)
    );

    assign {PCE, PCPlus4E, RD1E, RD2E, ImmExtE} = dataE;
    assign {Rs1E, Rs2E, RdE}                    = idxE;

    assign RegWriteE   = ctrlE.regWrite;
    assign ResultSrcE  = ctrlE.resultSrc;
    assign MemWriteE   = ctrlE.memWrite;
    assign JumpE       = ctrlE.jump;
    assign BranchE     = ctrlE.branch;
    assign ALUControlE = ctrlE.aluControl;
    assign ALUSrcE     = ctrlE.aluSrc;

endmodule

// File: tb/tb_register_id_ex_pipe.sv
// Bench for register_id_ex_pipe: directed plan plus random traffic against a stage model.
module tb_register_id_ex_pipe;

    typedef struct packed {
        logic [31:0] pc, pcPlus4, rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        regWrite, memWrite, jump, branch, aluSrc;
        logic [1:0]  resultSrc;
        logic [2:0]  aluControl;
    } stage_t;

    logic   clk = 1'b0;
    logic   reset, FlushE, StallE;
    stage_t d, expS;
    logic   expValid;
    int     errCnt = 0;
    int     chkCnt = 0;

    logic [31:0] PCE, PCPlus4E, RD1E, RD2E, ImmExtE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;

    always #5 clk = ~clk;

    register_id_ex_pipe dut (
        .clk         (clk),
        .reset       (reset),
        .FlushE      (FlushE),
`ifdef ID_EX_STALL_EN
        .StallE      (StallE),
`endif
        .PCD         (d.pc),
        .PCPlus4D    (d.pcPlus4),
        .RD1D        (d.rd1),
        .RD2D        (d.rd2),
        .ImmExtD     (d.imm),
        .Rs1D        (d.rs1),
        .Rs2D        (d.rs2),
        .RdD         (d.rd),
        .RegWriteD   (d.regWrite),
        .MemWriteD   (d.memWrite),
        .JumpD       (d.jump),
        .BranchD     (d.branch),
        .ALUSrcD     (d.aluSrc),
        .ResultSrcD  (d.resultSrc),
        .ALUControlD (d.aluControl),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ImmExtE     (ImmExtE),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .JumpE       (JumpE),
        .BranchE     (BranchE),
        .ALUSrcE     (ALUSrcE),
        .ResultSrcE  (ResultSrcE),
        .ALUControlE (ALUControlE)
    );

    task automatic chkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        chkCnt++;
        if (obs !== expv) begin
            errCnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic checkAll(input string tag);
        chkVal({tag, ".PCE"},         PCE,                  expS.pc);
        chkVal({tag, ".PCPlus4E"},    PCPlus4E,             expS.pcPlus4);
        chkVal({tag, ".RD1E"},        RD1E,                 expS.rd1);
        chkVal({tag, ".RD2E"},        RD2E,                 expS.rd2);
        chkVal({tag, ".ImmExtE"},     ImmExtE,              expS.imm);
        chkVal({tag, ".Rs1E"},        {27'd0, Rs1E},        {27'd0, expS.rs1});
        chkVal({tag, ".Rs2E"},        {27'd0, Rs2E},        {27'd0, expS.rs2});
        chkVal({tag, ".RdE"},         {27'd0, RdE},         {27'd0, expS.rd});
        chkVal({tag, ".RegWriteE"},   {31'd0, RegWriteE},   {31'd0, expS.regWrite});
        chkVal({tag, ".MemWriteE"},   {31'd0, MemWriteE},   {31'd0, expS.memWrite});
        chkVal({tag, ".JumpE"},       {31'd0, JumpE},       {31'd0, expS.jump});
        chkVal({tag, ".BranchE"},     {31'd0, BranchE},     {31'd0, expS.branch});
        chkVal({tag, ".ALUSrcE"},     {31'd0, ALUSrcE},     {31'd0, expS.aluSrc});
        chkVal({tag, ".ResultSrcE"},  {30'd0, ResultSrcE},  {30'd0, expS.resultSrc});
        chkVal({tag, ".ALUControlE"}, {29'd0, ALUControlE}, {29'd0, expS.aluControl});
    endtask

    // One clock edge: the model applies reset > flush > stall > load to the whole stage.
    task automatic step(input string tag, input logic rst, input logic fl, input logic st);
        reset  = rst;
        FlushE = fl;
        StallE = st;
        @(posedge clk);
        if (rst || fl) begin
            expS     = '0;
            expValid = 1'b1;
        end else if (st) begin
`ifndef ID_EX_STALL_EN
            expS = d;
`endif
        end else begin
            expS = d;
        end
        #1;
        if (expValid) checkAll(tag);
    endtask

    initial begin
        expValid = 1'b0;
        expS     = '0;
        reset    = 1'b1;
        FlushE   = 1'b0;
        StallE   = 1'b0;
        d        = '0;
        d.pcPlus4 = 32'h4;
        d.rd1     = 32'h11111111;
        #2;

        step("reset0", 1'b1, 1'b0, 1'b0);
        step("reset1", 1'b1, 1'b0, 1'b0);

        d.pc = 32'h10000000; d.pcPlus4 = 32'h10000004;
        d.rd1 = 32'hAAAA0001; d.rd2 = 32'hAAAA0002; d.imm = 32'h1234;
        d.rs1 = 5'd8; d.rs2 = 5'd9; d.rd = 5'd10;
        d.regWrite = 1'b1; d.resultSrc = 2'b01; d.jump = 1'b1;
        d.aluControl = 3'b011; d.aluSrc = 1'b1;
        step("load", 1'b0, 1'b0, 1'b0);

        d.pc = 32'h10000004; d.rd1 = 32'hBBBB0001; d.imm = 32'h5678; d.rd = 5'd14;
        d.memWrite = 1'b1; d.branch = 1'b1; d.resultSrc = 2'b10; d.aluControl = 3'b110;
        step("b2b", 1'b0, 1'b0, 1'b0);

        step("flush", 1'b0, 1'b1, 1'b0);
        step("reload", 1'b0, 1'b0, 1'b0);
        chkVal("reload.pcConst", PCE, 32'h10000004);

        d.pc = 32'h20000000; d.rd1 = 32'hCCCC0001; d.imm = 32'hDCBA; d.rd = 5'd18;
        d.regWrite = 1'b1; d.memWrite = 1'b1; d.jump = 1'b1; d.branch = 1'b1; d.aluSrc = 1'b1;
        d.resultSrc = 2'b11; d.aluControl = 3'b111;
        step("postFlush", 1'b0, 1'b0, 1'b0);

`ifdef ID_EX_STALL_EN
        d.pc = 32'h30000000; d.rd1 = 32'hDDDD0001; d.rd = 5'd3; d.regWrite = 1'b0;
        step("stall", 1'b0, 1'b0, 1'b1);
        chkVal("stall.pcConst", PCE, 32'h20000000);
        step("stallFlush", 1'b0, 1'b1, 1'b1);
`endif

        for (int i = 0; i < 300; i++) begin
            logic rst, fl, st;
            d.pc = $urandom; d.pcPlus4 = d.pc + 32'd4;
            d.rd1 = $urandom; d.rd2 = $urandom; d.imm = $urandom;
            d.rs1 = 5'($urandom); d.rs2 = 5'($urandom); d.rd = 5'($urandom);
            {d.regWrite, d.memWrite, d.jump, d.branch, d.aluSrc} = 5'($urandom);
            d.resultSrc = 2'($urandom); d.aluControl = 3'($urandom);
            rst = ($urandom_range(0, 31) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            st  = ($urandom_range(0, 3) == 0);
            step("rand", rst, fl, st);
        end

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
